// File: rtl/target_ddr_word_rx_pkg.sv
// Shared types and constants for the DDR word receiver.
// Optional CRC checking is enabled with the DDR_RX_CRC_EN macro.
package ddr_rx_pkg;

    localparam int unsigned WORD_W_DEF     = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned CRC_W          = 5;

    localparam logic [1:0]       PRE_DATA   = 2'b10;
    localparam logic [1:0]       PRE_TOKEN  = 2'b01;
    localparam logic [3:0]       TOKEN_CODE = 4'b1100;
    localparam logic [CRC_W-1:0] CRC5_POLY  = 5'b00101;
    localparam logic [CRC_W-1:0] CRC5_INIT  = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PARITY,
        ST_TOKEN,
        ST_CRC,
        ST_HALT
    } rx_state_e;

    // Registered one-cycle frame event pulses
    typedef struct packed {
        logic frame_done;
        logic parity_err;
        logic frame_err;
    } rx_evt_t;

    // One MSB-first serial step of CRC5 x^5+x^2+1
    function automatic logic [CRC_W-1:0] crc5_step(input logic [CRC_W-1:0] crc, input logic b);
        return {crc[CRC_W-2:0], 1'b0} ^ (((crc[CRC_W-1] ^ b) == 1'b1) ? CRC5_POLY : CRC_W'(0));
    endfunction

endpackage

// File: rtl/target_ddr_word_rx_if.sv
// Received-word stream: receiver (master) presents head word, consumer (slave) pops.
interface target_ddr_word_rx_if
    import ddr_rx_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
);
    logic [WORD_W-1:0] o_word_data;
    logic              o_word_valid;
    logic              i_word_ready;

    modport master (
        output o_word_data,
        output o_word_valid,
        input  i_word_ready
    );

    modport slave (
        input  o_word_data,
        input  o_word_valid,
        output i_word_ready
    );
endinterface

// File: rtl/target_ddr_word_rx_fifo.sv
// Received-word buffer: power-of-two depth, head word read straight from storage.
module ddr_rx_word_fifo
    import ddr_rx_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == CNT_W'(0));
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/target_ddr_word_rx.sv
// DDR serial word receiver: preamble/data/parity/token/CRC framing into a word FIFO.
// Define DDR_RX_CRC_EN to check the received CRC5 field against the payload.
module target_ddr_word_rx
    import ddr_rx_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_rst,
    input  logic                 i_sclgen_scl_pos_edge,
    input  logic                 i_sclgen_scl_neg_edge,
    input  logic                 i_sdahnd_rx_sda,
    input  logic                 i_ddrccc_rx_en,
    target_ddr_word_rx_if.master word_if,
    output logic                 o_frame_done,
    output logic                 o_parity_err,
    output logic                 o_crc_err,
    output logic                 o_frame_err,
    output logic                 o_overflow
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WORD_W-2:0] r_shift;
    logic [WORD_W-2:0] w_shift_nxt;
    logic [WORD_W-1:0] w_shift_in;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_nxt;
    logic              r_rx_en_d;
    logic              r_push;
    logic              w_push_nxt;
    rx_evt_t           r_evt;
    rx_evt_t           w_evt_nxt;
    logic              r_overflow;
    logic              w_overflow_nxt;
    logic              w_sample;
    logic              w_frame_start;
    logic              w_full;
    logic              w_drop;
`ifdef DDR_RX_CRC_EN
    logic [CRC_W-1:0]  r_crc;
    logic [CRC_W-1:0]  w_crc_nxt;
    logic              r_crc_err;
    logic              w_crc_err_nxt;
`endif

    // Expected {PA1, PA0}: PA1 over odd-indexed bits, PA0 over even-indexed bits inverted
    function automatic logic [1:0] word_parity(input logic [WORD_W-1:0] w);
        logic pa1;
        logic pa0;
        pa1 = 1'b0;
        pa0 = 1'b1;
        for (int i = 0; i < int'(WORD_W); i++) begin
            if ((i % 2) == 1) pa1 = pa1 ^ w[i];
            else              pa0 = pa0 ^ w[i];
        end
        return {pa1, pa0};
    endfunction

`ifdef DDR_RX_CRC_EN
    function automatic logic [CRC_W-1:0] crc5_word(input logic [CRC_W-1:0] crc,
                                                   input logic [WORD_W-1:0] w);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
            c = crc5_step(c, w[i]);
        end
        return c;
    endfunction
`endif

    // Either SCL edge is a DDR sample point; simultaneous pulses count once
    assign w_sample      = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
    assign w_shift_in    = {r_shift, i_sdahnd_rx_sda};
    assign w_frame_start = (r_state == ST_IDLE) & i_ddrccc_rx_en & ~r_rx_en_d;
    assign w_drop        = r_push & w_full & ~word_if.i_word_ready;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_word     <= '0;
            r_rx_en_d  <= 1'b0;
            r_push     <= 1'b0;
            r_evt      <= '0;
            r_overflow <= 1'b0;
`ifdef DDR_RX_CRC_EN
            r_crc      <= CRC5_INIT;
            r_crc_err  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_word     <= w_word_nxt;
            r_rx_en_d  <= i_ddrccc_rx_en;
            r_push     <= w_push_nxt;
            r_evt      <= w_evt_nxt;
            r_overflow <= w_overflow_nxt;
`ifdef DDR_RX_CRC_EN
            r_crc      <= w_crc_nxt;
            r_crc_err  <= w_crc_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_word_nxt     = r_word;
        w_push_nxt     = 1'b0;
        w_evt_nxt      = '0;
        w_overflow_nxt = r_overflow;
`ifdef DDR_RX_CRC_EN
        w_crc_nxt      = r_crc;
        w_crc_err_nxt  = 1'b0;
`endif

        if (!i_ddrccc_rx_en) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_en_d) begin
                        w_state_nxt = ST_PRE;
                        w_cnt_nxt   = '0;
`ifdef DDR_RX_CRC_EN
                        w_crc_nxt   = CRC5_INIT;
`endif
                    end
                end
                ST_PRE: begin
                    if (w_sample) begin
                        w_shift_nxt = w_shift_in[WORD_W-2:0];
                        if (r_cnt == CNT_W'(1)) begin
                            w_cnt_nxt = '0;
                            if (w_shift_in[1:0] == PRE_DATA) begin
                                w_state_nxt = ST_DATA;
                            end else if (w_shift_in[1:0] == PRE_TOKEN) begin
                                w_state_nxt = ST_TOKEN;
                            end else begin
                                w_evt_nxt.frame_err = 1'b1;
                                w_state_nxt         = ST_HALT;
                            end
                        end else begin
                            w_cnt_nxt = CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        w_shift_nxt = w_shift_in[WORD_W-2:0];
                        if (r_cnt == CNT_W'(WORD_W - 1)) begin
                            w_cnt_nxt   = '0;
                            w_word_nxt  = w_shift_in;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        w_shift_nxt = w_shift_in[WORD_W-2:0];
                        if (r_cnt == CNT_W'(1)) begin
                            w_cnt_nxt = '0;
                            if (w_shift_in[1:0] == word_parity(r_word)) begin
                                w_push_nxt  = 1'b1;
                                w_state_nxt = ST_PRE;
`ifdef DDR_RX_CRC_EN
                                w_crc_nxt   = crc5_word(r_crc, r_word);
`endif
                            end else begin
                                w_evt_nxt.parity_err = 1'b1;
                                w_state_nxt          = ST_HALT;
                            end
                        end else begin
                            w_cnt_nxt = CNT_W'(1);
                        end
                    end
                end
                ST_TOKEN: begin
                    if (w_sample) begin
                        w_shift_nxt = w_shift_in[WORD_W-2:0];
                        if (r_cnt == CNT_W'(3)) begin
                            w_cnt_nxt = '0;
                            if (w_shift_in[3:0] == TOKEN_CODE) begin
                                w_state_nxt = ST_CRC;
                            end else begin
                                w_evt_nxt.frame_err = 1'b1;
                                w_state_nxt         = ST_HALT;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_CRC: begin
                    if (w_sample) begin
                        w_shift_nxt = w_shift_in[WORD_W-2:0];
                        if (r_cnt == CNT_W'(CRC_W - 1)) begin
                            w_cnt_nxt            = '0;
                            w_evt_nxt.frame_done = 1'b1;
                            w_state_nxt          = ST_HALT;
`ifdef DDR_RX_CRC_EN
                            w_crc_err_nxt        = (w_shift_in[CRC_W-1:0] != r_crc);
`endif
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HALT: begin
                    w_state_nxt = ST_HALT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Overflow is sticky for the frame; a drop in the start cycle still wins
        if (w_frame_start) w_overflow_nxt = 1'b0;
        if (w_drop)        w_overflow_nxt = 1'b1;
    end

    ddr_rx_word_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_sys_clk),
        .i_rst_n     (i_sys_rst),
        .i_push      (r_push),
        .i_push_data (r_word),
        .i_pop       (word_if.i_word_ready),
        .o_data      (word_if.o_word_data),
        .o_valid     (word_if.o_word_valid),
        .o_full      (w_full)
    );

    assign o_frame_done = r_evt.frame_done;
    assign o_parity_err = r_evt.parity_err;
    assign o_frame_err  = r_evt.frame_err;
    assign o_overflow   = r_overflow;
`ifdef DDR_RX_CRC_EN
    assign o_crc_err    = r_crc_err;
`else
    assign o_crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_target_ddr_word_rx.sv
// Self-checking bench for target_ddr_word_rx: 16-bit and 8-bit instances, directed plus random frames.
module tb_target_ddr_word_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, pos, neg, sda, en16, en8;
    logic done16, perr16, cerr16, ferr16, ovf16;
    logic done8, perr8, cerr8, ferr8, ovf8;

    target_ddr_word_rx_if #(.WORD_W(16)) if16 ();
    target_ddr_word_rx_if #(.WORD_W(8))  if8 ();

    target_ddr_word_rx #(.WORD_W(16), .FIFO_DEPTH(4)) u16 (
        .i_sys_clk(clk), .i_sys_rst(rst_n),
        .i_sclgen_scl_pos_edge(pos), .i_sclgen_scl_neg_edge(neg),
        .i_sdahnd_rx_sda(sda), .i_ddrccc_rx_en(en16),
        .word_if(if16),
        .o_frame_done(done16), .o_parity_err(perr16), .o_crc_err(cerr16),
        .o_frame_err(ferr16), .o_overflow(ovf16)
    );

    target_ddr_word_rx #(.WORD_W(8), .FIFO_DEPTH(4)) u8 (
        .i_sys_clk(clk), .i_sys_rst(rst_n),
        .i_sclgen_scl_pos_edge(pos), .i_sclgen_scl_neg_edge(neg),
        .i_sdahnd_rx_sda(sda), .i_ddrccc_rx_en(en8),
        .word_if(if8),
        .o_frame_done(done8), .o_parity_err(perr8), .o_crc_err(cerr8),
        .o_frame_err(ferr8), .o_overflow(ovf8)
    );

    int n_chk = 0;
    int n_err = 0;

    // Observed event counts and popped words
    int c_done16 = 0, c_perr16 = 0, c_cerr16 = 0, c_ferr16 = 0, c_lone16 = 0;
    int c_done8 = 0, c_perr8 = 0, c_cerr8 = 0, c_ferr8 = 0, c_lone8 = 0;
    logic [15:0] pop16[$];
    logic [7:0]  pop8[$];

    // Reference model state
    int e_done16 = 0, e_perr16 = 0, e_cerr16 = 0, e_ferr16 = 0;
    int e_done8 = 0, e_perr8 = 0, e_cerr8 = 0, e_ferr8 = 0;
    logic [15:0] exp16[$];
    logic [7:0]  exp8[$];
    bit tx_q[$];
    bit pay_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            c_done16 += int'(done16); c_perr16 += int'(perr16);
            c_cerr16 += int'(cerr16); c_ferr16 += int'(ferr16);
            if (cerr16 && !done16) c_lone16++;
            if (if16.o_word_valid && if16.i_word_ready) pop16.push_back(if16.o_word_data);
            c_done8 += int'(done8); c_perr8 += int'(perr8);
            c_cerr8 += int'(cerr8); c_ferr8 += int'(ferr8);
            if (cerr8 && !done8) c_lone8++;
            if (if8.o_word_valid && if8.i_word_ready) pop8.push_back(if8.o_word_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Parity from bit counts: PA1 = odd-index ones mod 2, PA0 = even-index ones plus one mod 2
    function automatic logic [1:0] ref_par(input logic [31:0] w, input int n);
        int odd_ones = 0;
        int even_ones = 0;
        for (int i = 0; i < n; i++) begin
            if (w[i]) begin
                if (i % 2 == 1) odd_ones++;
                else            even_ones++;
            end
        end
        return {1'(odd_ones % 2), 1'((even_ones + 1) % 2)};
    endfunction

    // CRC as polynomial remainder of (init*x^n + M*x^5) mod (x^5+x^2+1)
    function automatic logic [4:0] ref_crc();
        bit a[$];
        logic [5:0] g = 6'b100101;
        int n = pay_q.size();
        a = pay_q;
        repeat (5) a.push_back(1'b0);
        for (int j = 0; j < 5; j++) a[j] = ~a[j];
        for (int j = 0; j < n; j++)
            if (a[j]) for (int k = 0; k < 6; k++) a[j+k] = a[j+k] ^ g[5-k];
        return {a[n], a[n+1], a[n+2], a[n+3], a[n+4]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_word(input logic [31:0] w, input int n, input logic [1:0] par);
        tx_q.push_back(1'b1); tx_q.push_back(1'b0);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(w[i]);
        tx_q.push_back(par[1]); tx_q.push_back(par[0]);
        if (par == ref_par(w, n))
            for (int i = n - 1; i >= 0; i--) pay_q.push_back(w[i]);
    endtask

    task automatic add_tail(input bit inv);
        logic [4:0] c;
        tx_q.push_back(1'b0); tx_q.push_back(1'b1);
        tx_q.push_back(1'b1); tx_q.push_back(1'b1);
        tx_q.push_back(1'b0); tx_q.push_back(1'b0);
        c = ref_crc();
        if (inv) c = ~c;
        for (int i = 4; i >= 0; i--) tx_q.push_back(c[i]);
    endtask

    task automatic send_bits();
        bit ph = 1'b0;
        foreach (tx_q[i]) begin
            step(); sda = tx_q[i]; pos = ~ph; neg = ph; ph = ~ph;
            step(); pos = 1'b0; neg = 1'b0; sda = 1'($urandom);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic run_frame(input bit is16);
        step(); if (is16) en16 = 1'b1; else en8 = 1'b1;
        step(); step();
        send_bits();
        repeat (4) step();
        en16 = 1'b0; en8 = 1'b0;
        repeat (3) step();
        tx_q.delete(); pay_q.delete();
    endtask

    task automatic counts16(input string tag);
        chk({tag, "_done"}, c_done16, e_done16);
        chk({tag, "_perr"}, c_perr16, e_perr16);
        chk({tag, "_cerr"}, c_cerr16, e_cerr16);
        chk({tag, "_ferr"}, c_ferr16, e_ferr16);
        chk({tag, "_crc_alone"}, c_lone16, 0);
    endtask

    task automatic drain16(input string tag);
        int n = exp16.size();
        step(); if16.i_word_ready = 1'b1;
        repeat (n + 2) step();
        if16.i_word_ready = 1'b0;
        step();
        chk({tag, "_npop"}, pop16.size(), n);
        foreach (exp16[i]) if (i < pop16.size()) chk({tag, "_word"}, pop16[i], exp16[i]);
        chk({tag, "_empty"}, if16.o_word_valid, 1'b0);
        pop16.delete(); exp16.delete();
    endtask

    logic [15:0] w5[5];
    logic [15:0] w1, wr;
    int nw;
    bit bad;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pos = 1'b0; neg = 1'b0; sda = 1'b0; en16 = 1'b0; en8 = 1'b0;
        if16.i_word_ready = 1'b0; if8.i_word_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", if16.o_word_valid, 1'b0);
        chk("rst_data", if16.o_word_data, 16'h0);
        chk("rst_ovf", ovf16, 1'b0);
        chk("rst_pulses", {done16, perr16, cerr16, ferr16}, 4'b0);
        rst_n = 1'b1;
        repeat (2) step();

        // Nominal frame with known word and parity
        add_word(32'hA5BD, 16, 2'b10); add_tail(1'b0);
        exp16.push_back(16'hA5BD); e_done16++;
        run_frame(1'b1);
        counts16("good");
        chk("good_valid", if16.o_word_valid, 1'b1);
        chk("good_head", if16.o_word_data, 16'hA5BD);
        drain16("good");

        // Wrong parity halts; trailing activity is ignored
        add_word(32'hA5BD, 16, 2'b11);
        tx_q.push_back(1'b1); tx_q.push_back(1'b0);
        repeat (20) tx_q.push_back(1'($urandom));
        e_perr16++;
        run_frame(1'b1);
        counts16("par");
        chk("par_empty", if16.o_word_valid, 1'b0);

        // Inverted CRC field
        add_word(32'hA5BD, 16, 2'b10); add_tail(1'b1);
        exp16.push_back(16'hA5BD); e_done16++;
`ifdef DDR_RX_CRC_EN
        e_cerr16++;
`endif
        run_frame(1'b1);
        counts16("crcinv");
        drain16("crcinv");

        // Five words into a four-deep FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            w5[i] = 16'($urandom);
            add_word(32'(w5[i]), 16, ref_par(32'(w5[i]), 16));
            if (i < 4) exp16.push_back(w5[i]);
        end
        add_tail(1'b0); e_done16++;
        run_frame(1'b1);
        counts16("ovf");
        chk("ovf_flag", ovf16, 1'b1);
        chk("ovf_head", if16.o_word_data, w5[0]);
        drain16("ovf");
        chk("ovf_sticky", ovf16, 1'b1);

        // Abort mid-word between two good frames
        w1 = 16'($urandom);
        add_word(32'(w1), 16, ref_par(32'(w1), 16)); add_tail(1'b0);
        exp16.push_back(w1); e_done16++;
        run_frame(1'b1);
        tx_q.push_back(1'b1); tx_q.push_back(1'b0);
        repeat (7) tx_q.push_back(1'($urandom));
        run_frame(1'b1);
        chk("abort_ovf_clear", ovf16, 1'b0);
        add_word(32'h0001, 16, ref_par(32'h0001, 16)); add_tail(1'b0);
        exp16.push_back(16'h0001); e_done16++;
        run_frame(1'b1);
        counts16("abort");
        drain16("abort");

        // Random frames with a consumer always ready
        if16.i_word_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            nw = $urandom_range(1, 3);
            bad = 1'b0;
            for (int k = 0; k < nw && !bad; k++) begin
                wr = 16'($urandom);
                if ($urandom_range(0, 5) == 0) begin
                    bad = 1'b1;
                    add_word(32'(wr), 16, ref_par(32'(wr), 16) ^ 2'b11);
                    e_perr16++;
                end else begin
                    add_word(32'(wr), 16, ref_par(32'(wr), 16));
                    exp16.push_back(wr);
                end
            end
            if (!bad) begin
                add_tail(1'b0); e_done16++;
            end
            run_frame(1'b1);
        end
        if16.i_word_ready = 1'b0;
        step();
        counts16("rand");
        chk("rand_npop", pop16.size(), exp16.size());
        foreach (exp16[i]) if (i < pop16.size()) chk("rand_word", pop16[i], exp16[i]);
        pop16.delete(); exp16.delete();

        // Bad preamble, then bad token
        tx_q.push_back(1'b1); tx_q.push_back(1'b1);
        repeat (10) tx_q.push_back(1'($urandom));
        e_ferr16++;
        run_frame(1'b1);
        counts16("pre11");
        chk("pre11_empty", if16.o_word_valid, 1'b0);
        wr = 16'($urandom);
        add_word(32'(wr), 16, ref_par(32'(wr), 16));
        exp16.push_back(wr);
        tx_q.push_back(1'b0); tx_q.push_back(1'b1);
        tx_q.push_back(1'b1); tx_q.push_back(1'b0); tx_q.push_back(1'b1); tx_q.push_back(1'b0);
        e_ferr16++;
        run_frame(1'b1);
        counts16("badtok");
        drain16("badtok");

        // 8-bit build
        add_word(32'hA5, 8, 2'b01); add_tail(1'b0);
        exp8.push_back(8'hA5); e_done8++;
        run_frame(1'b0);
        chk("w8_done", c_done8, e_done8);
        chk("w8_errs", c_perr8 + c_cerr8 + c_ferr8 + c_lone8, e_perr8 + e_cerr8 + e_ferr8);
        chk("w8_head", if8.o_word_data, 8'hA5);
        step(); if8.i_word_ready = 1'b1;
        repeat (3) step();
        if8.i_word_ready = 1'b0;
        step();
        chk("w8_npop", pop8.size(), exp8.size());
        if (pop8.size() > 0) chk("w8_word", pop8[0], exp8[0]);
        chk("w8_empty", if8.o_word_valid, 1'b0);
        counts16("w8_quiet16");

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 2; i++) begin
            wr = 16'($urandom);
            add_word(32'(wr), 16, ref_par(32'(wr), 16));
        end
        add_tail(1'b0); e_done16++;
        run_frame(1'b1);
        chk("prerst_valid", if16.o_word_valid, 1'b1);
        step(); en16 = 1'b1;
        step(); step();
        tx_q.push_back(1'b1); tx_q.push_back(1'b0);
        repeat (5) tx_q.push_back(1'($urandom));
        send_bits();
        tx_q.delete(); pay_q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", if16.o_word_valid, 1'b0);
        chk("arst_data", if16.o_word_data, 16'h0);
        chk("arst_ovf", ovf16, 1'b0);
        en16 = 1'b0;
        step(); rst_n = 1'b1;
        repeat (3) step();
        chk("postrst_valid", if16.o_word_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/target_ddr_word_rx.md
TARGET_DDR_WORD_RX -- requirements
Module: target_ddr_word_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 16, payload bits per DDR data word (even, 8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, received-word buffer depth (power of two, 2..16).
REQ-003 SHALL have port i_sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port i_sys_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_sclgen_scl_pos_edge  input  1  one-cycle pulse marking an SCL rising edge.
REQ-006 SHALL have port i_sclgen_scl_neg_edge  input  1  one-cycle pulse marking an SCL falling edge.
REQ-007 SHALL have port i_sdahnd_rx_sda  input  1  sampled SDA level.
REQ-008 SHALL have port i_ddrccc_rx_en  input  1  receive enable; frame active while high.
REQ-009 SHALL have port o_word_data  output  WORD_W  FIFO head word.
REQ-010 SHALL have port o_word_valid  output  1  FIFO not empty.
REQ-011 SHALL have port i_word_ready  input  1  consumer pop; pop occurs when valid and ready.
REQ-012 SHALL have port o_frame_done  output  1  one-cycle pulse after a complete CRC word.
REQ-013 SHALL have port o_parity_err, o_crc_err, o_frame_err  output  1 each  one-cycle error pulses.
REQ-014 SHALL have port o_overflow  output  1  sticky; word dropped because FIFO full.

Function
REQ-015 SHALL sample SDA on every cycle where either edge pulse is high (DDR); both pulses high is impossible and SHALL be treated as one sample.
REQ-016 SHALL implement states IDLE, PRE, DATA, PARITY, TOKEN, CRC, HALT.
REQ-017 IDLE->PRE when i_ddrccc_rx_en rises; CRC accumulator loads 5'b11111.
REQ-018 PRE collects 2 bits: 2'b10 -> DATA, 2'b01 -> TOKEN, 2'b00/2'b11 -> o_frame_err pulse, HALT.
REQ-019 DATA shifts WORD_W bits MSB first, then PARITY collects 2 bits {PA1,PA0}.
REQ-020 PA1 SHALL equal XOR of odd-indexed payload bits; PA0 SHALL equal XOR of even-indexed bits XOR 1.
REQ-021 Parity match: word pushed to FIFO one cycle after last parity sample, CRC updated over the WORD_W bits, return to PRE.
REQ-022 Parity mismatch: word not pushed, o_parity_err pulse, HALT.
REQ-023 TOKEN collects 4 bits; not 4'b1100 -> o_frame_err, HALT; else CRC collects 5 bits, then o_frame_done pulse, HALT.
REQ-024 CRC5 polynomial x^5+x^2+1, MSB-first serial, over all payload bits since frame start.
REQ-025 HALT ignores SDA until i_ddrccc_rx_en low, then IDLE.
REQ-026 i_ddrccc_rx_en low in any state SHALL abort to IDLE next cycle, discard partial word, keep FIFO contents.
REQ-027 Push when full and no pop: word dropped, o_overflow set until next IDLE->PRE; push and pop same cycle when full SHALL succeed.
REQ-028 Pop when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH; o_word_data SHALL be the head word, combinational from storage.

Reset
REQ-029 On i_sys_rst low: state IDLE, FIFO empty, CRC 5'b11111, o_word_valid 0, o_word_data 0, all pulses 0, o_overflow 0.
REQ-030 Reset mid-frame SHALL discard all received words and take effect without a clock.

Configuration
REQ-031 With DDR_RX_CRC_EN defined: CRC field compared to accumulator; mismatch -> o_crc_err pulse in same cycle as o_frame_done.
REQ-032 Without DDR_RX_CRC_EN: no accumulator logic, CRC bits consumed and discarded, o_crc_err tied 0; token check retained.

Structure
REQ-033 Package ddr_rx_pkg SHALL hold state encoding, preamble codes 2'b10/2'b01, token 4'b1100, CRC5 polynomial and init value.
REQ-034 FIFO SHALL be a sub-module ddr_rx_word_fifo (WORD_W, FIFO_DEPTH parameters).

Verification
REQ-035 Frame: PRE 10, data 16'hA5BD, parity 2'b10, PRE 01, token 1100, correct CRC -> one word 16'hA5BD, o_frame_done, no errors.
REQ-036 Same frame, parity 2'b11 -> o_parity_err pulse, FIFO empty, later SDA activity ignored until rx_en low.
REQ-037 Same frame, CRC field inverted, macro defined -> o_crc_err with o_frame_done; macro undefined -> no o_crc_err.
REQ-038 Five data words, FIFO_DEPTH=4, i_word_ready low -> four words held, o_overflow 1; fifth word absent.
REQ-039 i_ddrccc_rx_en dropped after 7 data bits, then new frame with 16'h0001 -> only 16'h0001 delivered, prior FIFO words intact.
REQ-040 Preamble 2'b11 -> o_frame_err pulse, HALT; WORD_W=8 build repeats REQ-035 with 8'hA5 and its parity.
